// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the round datapath.
// Every product is an xtime chain; there are no multipliers or lookup tables.
package aes_pkg;

   typedef logic [127:0] aes_state_t;
   typedef logic [31:0]  aes_col_t;

   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      IDLE_S,
      RUN_S,
      DONE_S
   } mc_state_e;

   // Multiply by x modulo the AES polynomial 0x11b.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gf_mulb(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_muld(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gf_mule(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns / InvMixColumns of a single 32-bit column.
// Row r of the column lives in col_i[8r+:8].
module mix_column_word
   import aes_pkg::*;
#(
   parameter bit OP = 1'b1
) (
   input  aes_col_t col_i,
   output aes_col_t col_o
);

   for (genvar i = 0; i < 4; i++) begin : g_row
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] a2;
      logic [7:0] a3;

      // a0 is this output's own row; a1..a3 walk the column cyclically.
      assign a0 = col_i[8*i +: 8];
      assign a1 = col_i[8*((i+1)%4) +: 8];
      assign a2 = col_i[8*((i+2)%4) +: 8];
      assign a3 = col_i[8*((i+3)%4) +: 8];

      if (OP) begin : g_fwd
         assign col_o[8*i +: 8] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
      end else begin : g_inv
         assign col_o[8*i +: 8] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
      end
   end

endmodule

// File: rtl/mix_columns.sv
// MixColumns round stage: one column per cycle through a shared column mixer,
// with a start/done handshake and a registered result state.
module mix_columns
   import aes_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter bit OP    = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_i,
   input  logic             start_i,
   output logic [WIDTH-1:0] s_o,
   output logic             busy_o,
   output logic             done_o
);

   mc_state_e  state_q;
   logic [1:0] colIdx_q;
   aes_state_t s_q;
   aes_state_t res_q;
   aes_state_t sOut_q;
   logic       done_q;
   aes_col_t   colSel_d;
   aes_col_t   mixCol_d;

   assign colSel_d = s_q[32*colIdx_q +: 32];

   mix_column_word #(.OP(OP)) u_word (
      .col_i (colSel_d),
      .col_o (mixCol_d)
   );

   // start_i is only honoured in IDLE_S and DONE_S, so a request during RUN_S is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE_S;
         colIdx_q <= 2'd0;
         s_q      <= '0;
         res_q    <= '0;
         sOut_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE_S: begin
               if (start_i) begin
                  s_q      <= s_i;
                  colIdx_q <= 2'd0;
                  state_q  <= RUN_S;
               end
            end
            RUN_S: begin
               res_q[32*colIdx_q +: 32] <= mixCol_d;
               colIdx_q                 <= colIdx_q + 2'd1;
               if (colIdx_q == 2'(NUM_COLS - 1)) begin
                  state_q <= DONE_S;
               end
            end
            DONE_S: begin
               sOut_q <= res_q;
               done_q <= 1'b1;
               if (start_i) begin
                  s_q      <= s_i;
                  colIdx_q <= 2'd0;
                  state_q  <= RUN_S;
               end else begin
                  state_q <= IDLE_S;
               end
            end
            default: begin
               state_q <= IDLE_S;
            end
         endcase
      end
   end

   assign s_o    = sOut_q;
   assign done_o = done_q;
   assign busy_o = (state_q == RUN_S) || (state_q == DONE_S);

endmodule

// File: tb/tb_mix_columns.sv
// Directed self-checking bench for mix_columns, running a forward (OP=1)
// and an inverse (OP=0) instance side by side on a shared clock and reset.
module tb_mix_columns;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] sIFwd, sOFwd, sIInv, sOInv;
   logic         startFwd, startInv;
   logic         busyFwd, busyInv;
   logic         doneFwd, doneInv;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   mix_columns #(.WIDTH(128), .OP(1'b1)) dutFwd (
      .clk     (clk),
      .rst     (rst),
      .s_i     (sIFwd),
      .start_i (startFwd),
      .s_o     (sOFwd),
      .busy_o  (busyFwd),
      .done_o  (doneFwd)
   );

   mix_columns #(.WIDTH(128), .OP(1'b0)) dutInv (
      .clk     (clk),
      .rst     (rst),
      .s_i     (sIInv),
      .start_i (startInv),
      .s_o     (sOInv),
      .busy_o  (busyInv),
      .done_o  (doneInv)
   );

   // FIPS-197 listings put byte 0 in the most significant position; the DUT wants it at bit 0.
   function automatic logic [127:0] fips(input logic [127:0] f);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = f[127-8*k -: 8];
      return r;
   endfunction

   // Shift-and-add GF(2^8) multiply, independent of the xtime chains in the RTL.
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] modelMix(input logic [127:0] s, input bit inv);
      logic [7:0]   coef [4];
      logic [127:0] r;
      logic [7:0]   acc;
      if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gfMul(s[32*c + 8*((i+k)%4) +: 8], coef[k]);
            r[32*c + 8*i +: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic logic getDone(input bit inv);
      return inv ? doneInv : doneFwd;
   endfunction

   function automatic logic getBusy(input bit inv);
      return inv ? busyInv : busyFwd;
   endfunction

   function automatic logic [127:0] getOut(input bit inv);
      return inv ? sOInv : sOFwd;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit inv, input logic st, input logic [127:0] d);
      if (inv) begin
         startInv = st;
         sIInv    = d;
      end else begin
         startFwd = st;
         sIFwd    = d;
      end
   endtask

   // One transaction; lat is the number of edges after the accept edge until done_o is seen (-1 on timeout).
   task automatic runOp(input bit inv, input logic [127:0] din, output logic [127:0] dout, output int lat);
      drive(inv, 1'b1, din);
      tick();
      drive(inv, 1'b0, ~din);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (getDone(inv)) begin
            lat = k;
            break;
         end
      end
      dout = getOut(inv);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b1, {4{32'hdeadbeef}});
      drive(1'b1, 1'b1, {4{32'hdeadbeef}});
      tick();
      tick();
      for (int op = 0; op < 2; op++) begin
         compared++;
         if (getOut(op[0]) !== 128'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_s_o op%0d: got %h expected 0", op, getOut(op[0]));
         end
         compared++;
         if (getDone(op[0]) !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_done op%0d: got %b expected 0", op, getDone(op[0]));
         end
         compared++;
         if (getBusy(op[0]) !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy op%0d: got %b expected 0", op, getBusy(op[0]));
         end
      end
      drive(1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, '0);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_columns();
      logic [31:0]  cin  [4] = '{32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5};
      logic [31:0]  cout [4] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6};
      logic [127:0] inS, expS, got;
      int           lat;
      for (int i = 0; i < 4; i++) begin
         inS  = fips({cin[i], 96'h0});
         expS = fips({cout[i], 96'h0});
         runOp(1'b0, inS, got, lat);
         compared++;
         if (got !== expS) begin
            mismatched++;
            $display("[TB] FAIL col_fwd%0d: got %h expected %h", i, got, expS);
         end
         compared++;
         if (lat !== 5) begin
            mismatched++;
            $display("[TB] FAIL col_fwd_lat%0d: got %0d expected 5", i, lat);
         end
         runOp(1'b1, expS, got, lat);
         compared++;
         if (got !== inS) begin
            mismatched++;
            $display("[TB] FAIL col_inv%0d: got %h expected %h", i, got, inS);
         end
      end
   endtask

   task automatic test_full_state();
      logic [127:0] inS  = fips(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
      logic [127:0] expS = fips(128'h046681e5_e0cb199a_48f8d37a_2806264c);
      logic [127:0] got;
      int           lat;
      runOp(1'b0, inS, got, lat);
      compared++;
      if (got !== expS) begin
         mismatched++;
         $display("[TB] FAIL full_fwd: got %h expected %h", got, expS);
      end
      compared++;
      if (lat !== 5) begin
         mismatched++;
         $display("[TB] FAIL full_fwd_lat: got %0d expected 5", lat);
      end
      runOp(1'b1, expS, got, lat);
      compared++;
      if (got !== inS) begin
         mismatched++;
         $display("[TB] FAIL full_inv: got %h expected %h", got, inS);
      end
      compared++;
      if (lat !== 5) begin
         mismatched++;
         $display("[TB] FAIL full_inv_lat: got %0d expected 5", lat);
      end
   endtask

   task automatic test_fixed_points();
      logic [127:0] pats [3] = '{{16{8'h01}}, {16{8'hc6}}, 128'h0};
      logic [127:0] got;
      int           lat, pulses;
      for (int op = 0; op < 2; op++) begin
         for (int p = 0; p < 3; p++) begin
            runOp(op[0], pats[p], got, lat);
            pulses = (lat > 0) ? 1 : 0;
            for (int k = 0; k < 8; k++) begin
               tick();
               if (getDone(op[0])) pulses++;
            end
            compared++;
            if (got !== pats[p]) begin
               mismatched++;
               $display("[TB] FAIL fixed op%0d pat%0d: got %h expected %h", op, p, got, pats[p]);
            end
            compared++;
            if (pulses !== 1) begin
               mismatched++;
               $display("[TB] FAIL fixed_pulses op%0d pat%0d: got %0d expected 1", op, p, pulses);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] plain [3];
      logic [127:0] mixed [3];
      logic [127:0] src   [3];
      logic [127:0] dst   [3];
      int           gap, extra;
      plain = '{fips(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5), {16{8'h01}},
                fips({32'hdb135345, 96'h0})};
      mixed = '{fips(128'h046681e5_e0cb199a_48f8d37a_2806264c), {16{8'h01}},
                fips({32'h8e4da1bc, 96'h0})};
      for (int op = 0; op < 2; op++) begin
         src = op ? mixed : plain;
         dst = op ? plain : mixed;
         drive(op[0], 1'b1, src[0]);
         tick();
         drive(op[0], 1'b1, src[1]);
         for (int n = 0; n < 3; n++) begin
            gap = -1;
            for (int k = 1; k <= 20; k++) begin
               tick();
               if (getDone(op[0])) begin
                  gap = k;
                  break;
               end
            end
            // The run already in flight keeps its captured state whatever s_i now does.
            if (n == 0) drive(op[0], 1'b1, src[2]);
            if (n == 1) drive(op[0], 1'b0, 128'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0);
            compared++;
            if (getOut(op[0]) !== dst[n]) begin
               mismatched++;
               $display("[TB] FAIL b2b op%0d run%0d: got %h expected %h", op, n, getOut(op[0]), dst[n]);
            end
            compared++;
            if (gap !== 5) begin
               mismatched++;
               $display("[TB] FAIL b2b_gap op%0d run%0d: got %0d expected 5", op, n, gap);
            end
         end
         extra = 0;
         for (int k = 0; k < 10; k++) begin
            tick();
            if (getDone(op[0])) extra++;
         end
         compared++;
         if (extra !== 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_tail op%0d: got %0d pulses expected 0", op, extra);
         end
      end
   endtask

   task automatic test_start_in_run();
      logic [127:0] inS = fips({32'hf20a225c, 96'h0});
      logic [127:0] expS;
      int           pulses;
      for (int op = 0; op < 2; op++) begin
         expS = modelMix(inS, op[0]);
         drive(op[0], 1'b1, inS);
         tick();
         drive(op[0], 1'b0, '0);
         tick();
         drive(op[0], 1'b1, {16{8'h77}});
         tick();
         drive(op[0], 1'b0, '0);
         pulses = 0;
         for (int k = 0; k < 15; k++) begin
            tick();
            if (getDone(op[0])) begin
               pulses++;
               compared++;
               if (getOut(op[0]) !== expS) begin
                  mismatched++;
                  $display("[TB] FAIL run_start_data op%0d: got %h expected %h", op, getOut(op[0]), expS);
               end
            end
         end
         compared++;
         if (pulses !== 1) begin
            mismatched++;
            $display("[TB] FAIL run_start_pulses op%0d: got %0d expected 1", op, pulses);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [127:0] inS  = fips(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
      logic [127:0] expS = fips(128'h046681e5_e0cb199a_48f8d37a_2806264c);
      logic [127:0] src, dst, got;
      int           lat, pulses;
      for (int op = 0; op < 2; op++) begin
         src = op ? expS : inS;
         dst = op ? inS : expS;
         runOp(op[0], src, got, lat);
         drive(op[0], 1'b1, src);
         tick();
         drive(op[0], 1'b0, '0);
         tick();
         tick();
         rst = 1'b1;
         tick();
         rst = 1'b0;
         compared++;
         if (getOut(op[0]) !== 128'h0) begin
            mismatched++;
            $display("[TB] FAIL abort_s_o op%0d: got %h expected 0", op, getOut(op[0]));
         end
         compared++;
         if (getDone(op[0]) !== 1'b0 || getBusy(op[0]) !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_flags op%0d: got done=%b busy=%b expected 0/0", op, getDone(op[0]), getBusy(op[0]));
         end
         pulses = 0;
         for (int k = 0; k < 8; k++) begin
            tick();
            if (getDone(op[0])) pulses++;
         end
         compared++;
         if (pulses !== 0) begin
            mismatched++;
            $display("[TB] FAIL abort_pulses op%0d: got %0d expected 0", op, pulses);
         end
         runOp(op[0], src, got, lat);
         compared++;
         if (got !== dst || lat !== 5) begin
            mismatched++;
            $display("[TB] FAIL abort_restart op%0d: got %h lat %0d expected %h lat 5", op, got, lat, dst);
         end
      end
   endtask

   task automatic test_random();
      logic [127:0] orig, mid, back, expMid;
      int           lat1, lat2;
      for (int n = 0; n < 1000; n++) begin
         orig   = {$urandom, $urandom, $urandom, $urandom};
         expMid = modelMix(orig, 1'b0);
         runOp(1'b0, orig, mid, lat1);
         runOp(1'b1, mid, back, lat2);
         compared++;
         if (mid !== expMid || lat1 !== 5) begin
            mismatched++;
            $display("[TB] FAIL rand_fwd%0d: got %h lat %0d expected %h lat 5", n, mid, lat1, expMid);
         end
         compared++;
         if (back !== orig || lat2 !== 5) begin
            mismatched++;
            $display("[TB] FAIL rand_roundtrip%0d: got %h lat %0d expected %h lat 5", n, back, lat2, orig);
         end
      end
   endtask

   initial begin
      test_reset();
      test_columns();
      test_full_state();
      test_fixed_points();
      test_back_to_back();
      test_start_in_run();
      test_reset_mid_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
